// File: rtl/pm_pkg.sv
// Shared widths and helpers for the multi-flow packet manager: byte swapping
// of header fields and the round-robin pick used by the arbiter.
package pm_pkg;

  localparam int MAC_W     = 48;
  localparam int SIZE_W    = 11;
  localparam int ETYPE_W   = 16;
  localparam int PAYLOAD_W = 8;
  localparam int MAX_FLOWS = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } pick_t;

  function automatic logic [47:0] byte_swap48(input logic [47:0] v);
    logic [47:0] r;
    for (int b = 0; b < 6; b++) r[8*(5-b) +: 8] = v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [15:0] byte_swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  // First set request at or above ptr, wrapping at n. Scanning from the far
  // end lets the nearest hit overwrite earlier ones.
  function automatic pick_t pick_rr(input logic [15:0] req, input logic [3:0] ptr, input int n);
    pick_t r;
    int    j;
    r = '0;
    for (int k = MAX_FLOWS - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (req[j[3:0]]) begin
          r.valid = 1'b1;
          r.idx   = j[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pm_rr_arbiter.sv
// Round-robin arbiter over NUM_FLOWS requests; the pointer moves past the
// granted flow whenever advance is high.
module pm_rr_arbiter
  import pm_pkg::*;
#(
  parameter int NUM_FLOWS = 4,
  parameter int FLOW_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FLOWS-1:0] req,
  input  logic                 advance,
  output logic [NUM_FLOWS-1:0] grant,
  output logic [FLOW_W-1:0]    grant_idx,
  output logic                 grant_valid
);

  localparam logic [3:0] LAST = 4'(NUM_FLOWS - 1);

  logic [3:0]  ptr_q;
  logic [15:0] req_ext;
  pick_t       pick;

  always_comb begin
    req_ext                 = '0;
    req_ext[NUM_FLOWS-1:0]  = req;
  end

  assign pick        = pick_rr(req_ext, ptr_q, NUM_FLOWS);
  assign grant_valid = pick.valid;
  assign grant_idx   = FLOW_W'(pick.idx);

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_FLOWS; i++) grant[i] = pick.valid && (pick.idx == 4'(i));
  end

  // With a single flow LAST is 0, so the pointer never leaves 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && pick.valid) begin
      ptr_q <= (pick.idx == LAST) ? 4'd0 : pick.idx + 4'd1;
    end
  end

endmodule

// File: rtl/multi_flow_packet_manager.sv
// Multi-flow Ethernet TX command generator: per-flow rate accumulators feed
// saturating credit counters, drained one command per cycle by a round-robin
// arbiter. Optional per-flow drop counters are enabled with PM_STATS_EN.
// Handshake: a command is issued at an edge where fifo_wr_ready=1 and some
// flow holds credit; fifo_wr_enable and the header are valid the next cycle.
module multi_flow_packet_manager
  import pm_pkg::*;
#(
  parameter int NUM_FLOWS = 4,
  parameter int FLOW_W    = 4,
  parameter int ACC_W     = 16,
  parameter logic [NUM_FLOWS*ACC_W-1:0]     RATE_INC  = {NUM_FLOWS{16'h1000}},
  parameter int PEND_W    = 4,
  parameter logic [NUM_FLOWS*SIZE_W-1:0]    SIZE      = {NUM_FLOWS{11'd64}},
  parameter logic [NUM_FLOWS*PAYLOAD_W-1:0] PAYLOAD   = {NUM_FLOWS{8'h1A}},
  parameter logic [NUM_FLOWS*MAC_W-1:0]     MAC_D     = {NUM_FLOWS{48'hBC9A78563412}},
  parameter logic [NUM_FLOWS*MAC_W-1:0]     MAC_S     = {NUM_FLOWS{48'h111111111111}},
  parameter logic [NUM_FLOWS*ETYPE_W-1:0]   ETHERTYPE = {NUM_FLOWS{16'h0800}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FLOWS-1:0] flow_en,
  input  logic                 fifo_wr_ready,
  output logic                 fifo_wr_enable,
  output logic [FLOW_W-1:0]    flow_id,
  output logic [SIZE_W-1:0]    size,
  output logic [MAC_W-1:0]     d_mac,
  output logic [MAC_W-1:0]     s_mac,
  output logic [ETYPE_W-1:0]   ethertype,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 pending_any
`ifdef PM_STATS_EN
  ,
  output logic [NUM_FLOWS*16-1:0] drop_count
`endif
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [ACC_W-1:0]     acc       [NUM_FLOWS];
  logic [ACC_W:0]       sum       [NUM_FLOWS];
  logic [PEND_W-1:0]    pend      [NUM_FLOWS];
  logic [PEND_W-1:0]    pend_next [NUM_FLOWS];
  logic [NUM_FLOWS-1:0] credit, take, pend_nz, pend_next_nz;
  logic [NUM_FLOWS-1:0] grant;
  logic [FLOW_W-1:0]    grant_idx;
  logic                 grant_valid;
  logic                 issue;

  logic [SIZE_W-1:0]    sel_size;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic [MAC_W-1:0]     sel_dmac, sel_smac;
  logic [ETYPE_W-1:0]   sel_etype;

  pm_rr_arbiter #(
    .NUM_FLOWS (NUM_FLOWS),
    .FLOW_W    (FLOW_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (pend_nz),
    .advance     (issue),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign issue = fifo_wr_ready && grant_valid;

  always_comb begin
    for (int i = 0; i < NUM_FLOWS; i++) begin
      sum[i]          = {1'b0, acc[i]} + {1'b0, RATE_INC[i*ACC_W +: ACC_W]};
      credit[i]       = flow_en[i] && sum[i][ACC_W];
      pend_nz[i]      = (pend[i] != '0);
      take[i]         = issue && grant[i];
      pend_next[i]    = pend[i];
      // A credit arriving on a full counter is lost; credit plus issue cancels.
      if (credit[i] && !take[i]) begin
        if (pend[i] != PEND_MAX) pend_next[i] = pend[i] + 1'b1;
      end else if (!credit[i] && take[i]) begin
        pend_next[i] = pend[i] - 1'b1;
      end
      pend_next_nz[i] = (pend_next[i] != '0);
    end
  end

  always_comb begin
    sel_size    = '0;
    sel_payload = '0;
    sel_dmac    = '0;
    sel_smac    = '0;
    sel_etype   = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      if (grant[i]) begin
        sel_size    = SIZE[i*SIZE_W +: SIZE_W];
        sel_payload = PAYLOAD[i*PAYLOAD_W +: PAYLOAD_W];
        sel_dmac    = MAC_D[i*MAC_W +: MAC_W];
        sel_smac    = MAC_S[i*MAC_W +: MAC_W];
        sel_etype   = ETHERTYPE[i*ETYPE_W +: ETYPE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FLOWS; i++) begin
      if (rst) begin
        acc[i]  <= '0;
        pend[i] <= '0;
      end else begin
        acc[i]  <= flow_en[i] ? sum[i][ACC_W-1:0] : '0;
        pend[i] <= pend_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pending_any <= 1'b0;
    else     pending_any <= |pend_next_nz;
  end

  // Header outputs are held at zero on every cycle without a write.
  always_ff @(posedge clk) begin
    if (rst || !issue) begin
      fifo_wr_enable <= 1'b0;
      flow_id        <= '0;
      size           <= '0;
      d_mac          <= '0;
      s_mac          <= '0;
      ethertype      <= '0;
      payload        <= '0;
    end else begin
      fifo_wr_enable <= 1'b1;
      flow_id        <= grant_idx;
      size           <= sel_size;
      d_mac          <= byte_swap48(sel_dmac);
      s_mac          <= byte_swap48(sel_smac);
      ethertype      <= byte_swap16(sel_etype);
      payload        <= sel_payload;
    end
  end

`ifdef PM_STATS_EN
  logic [15:0] drop_cnt [NUM_FLOWS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FLOWS; i++) begin
      if (rst) begin
        drop_cnt[i] <= '0;
      end else if (credit[i] && !take[i] && (pend[i] == PEND_MAX) && (drop_cnt[i] != 16'hFFFF)) begin
        drop_cnt[i] <= drop_cnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_FLOWS; g++) begin : g_drop
    assign drop_count[g*16 +: 16] = drop_cnt[g];
  end
`endif

endmodule

// File: tb/tb_multi_flow_packet_manager.sv
// Bench for multi_flow_packet_manager: three two-flow instances with different
// rate settings, a phase table plus hand-written corner-case sequences.
module tb_multi_flow_packet_manager;

  localparam int NI = 3;
  localparam int CW = 4 + 11 + 48 + 48 + 16 + 8;

  logic             clk;
  logic             rst;
  logic [1:0]       en_v   [NI];
  logic             rdy    [NI];
  logic             we     [NI];
  logic [3:0]       fid    [NI];
  logic [10:0]      sz     [NI];
  logic [47:0]      dmac   [NI];
  logic [47:0]      smac   [NI];
  logic [15:0]      etype  [NI];
  logic [7:0]       pay    [NI];
  logic             pa     [NI];
  logic [CW-1:0]    bundle [NI];
`ifdef PM_STATS_EN
  logic [31:0]      drops  [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam logic [31:0] INC = (g == 0) ? {16'h8000, 16'h4000} :
                                  (g == 1) ? {16'h8000, 16'h8000} :
                                             {16'h8000, 16'hFFFF};
    multi_flow_packet_manager #(
      .NUM_FLOWS (2),
      .FLOW_W    (4),
      .ACC_W     (16),
      .RATE_INC  (INC),
      .PEND_W    (4),
      .SIZE      ({11'd1500, 11'd64}),
      .PAYLOAD   ({8'h2B, 8'h1A}),
      .MAC_D     ({48'h665544332211, 48'hBC9A78563412}),
      .MAC_S     ({2{48'h111111111111}}),
      .ETHERTYPE ({16'h86DD, 16'h0800})
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .flow_en        (en_v[g]),
      .fifo_wr_ready  (rdy[g]),
      .fifo_wr_enable (we[g]),
      .flow_id        (fid[g]),
      .size           (sz[g]),
      .d_mac          (dmac[g]),
      .s_mac          (smac[g]),
      .ethertype      (etype[g]),
      .payload        (pay[g]),
      .pending_any    (pa[g])
`ifdef PM_STATS_EN
      ,
      .drop_count     (drops[g])
`endif
    );
    assign bundle[g] = {fid[g], sz[g], dmac[g], smac[g], etype[g], pay[g]};
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       inst;
    logic [1:0] en;
    logic     rdy;
    int       cycles;
    int       n_wr;
    int       first_fid;
    bit       alt;
    int       gap;
  } phase_t;

  logic [CW-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int act      = 0;
  int cyc      = 0;
  int last_wr  = -1;
  int wr_cnt   = 0;
  int gap_exp  = 0;

  function automatic logic [CW-1:0] exp_cmd(input int f);
    if (f == 0) return {4'd0, 11'd64, 48'h123456789ABC, 48'h111111111111, 16'h0008, 8'h1A};
    else        return {4'd1, 11'd1500, 48'h112233445566, 48'h111111111111, 16'hDD86, 8'h2B};
  endfunction

  task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic set_in(input int inst, input logic [1:0] e, input logic r);
    for (int g = 0; g < NI; g++) begin
      en_v[g] = 2'b00;
      rdy[g]  = 1'b0;
    end
    en_v[inst] = e;
    rdy[inst]  = r;
  endtask

  // One cycle: advance to the falling edge and score the active instance.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int g = 0; g < NI; g++) begin
      if (g != act) check($sformatf("idle_inst%0d_we", g), CW'(we[g]), '0);
    end
    if (we[act]) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", CW'(we[act]), '0);
      end else begin
        check("cmd", bundle[act], exp_q.pop_front());
      end
      if (gap_exp != 0 && last_wr >= 0) check("write_gap", CW'(cyc - last_wr), CW'(gap_exp));
      last_wr = cyc;
      wr_cnt++;
    end else begin
      check("idle_outputs_zero", bundle[act], '0);
    end
  endtask

  task automatic do_reset(input int inst);
    exp_q.delete();
    act     = inst;
    last_wr = -1;
    wr_cnt  = 0;
    gap_exp = 0;
    rst     = 1'b1;
    set_in(inst, 2'b00, 1'b0);
    step();
    step();
    check("reset_pending_any", CW'(pa[inst]), '0);
    rst = 1'b0;
  endtask

  task automatic push_n(input int n, input int first, input bit alt);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_cmd(alt ? (first ^ (k & 1)) : first));
  endtask

  phase_t tbl [5];

  initial begin
    tbl[0] = '{inst: 0, en: 2'b01, rdy: 1'b1, cycles: 40, n_wr: 9,  first_fid: 0, alt: 1'b0, gap: 4};
    tbl[1] = '{inst: 0, en: 2'b10, rdy: 1'b1, cycles: 20, n_wr: 9,  first_fid: 1, alt: 1'b0, gap: 2};
    tbl[2] = '{inst: 1, en: 2'b11, rdy: 1'b1, cycles: 20, n_wr: 18, first_fid: 0, alt: 1'b1, gap: 1};
    tbl[3] = '{inst: 0, en: 2'b01, rdy: 1'b0, cycles: 30, n_wr: 0,  first_fid: 0, alt: 1'b0, gap: 0};
    tbl[4] = '{inst: 1, en: 2'b00, rdy: 1'b1, cycles: 10, n_wr: 0,  first_fid: 0, alt: 1'b0, gap: 0};

    rst = 1'b1;
    set_in(0, 2'b00, 1'b0);

    for (int p = 0; p < 5; p++) begin
      do_reset(tbl[p].inst);
      push_n(tbl[p].n_wr, tbl[p].first_fid, tbl[p].alt);
      gap_exp = tbl[p].gap;
      set_in(tbl[p].inst, tbl[p].en, tbl[p].rdy);
      for (int c = 0; c < tbl[p].cycles; c++) step();
      check($sformatf("phase%0d_write_count", p), CW'(wr_cnt), CW'(tbl[p].n_wr));
      check($sformatf("phase%0d_leftover", p), CW'(exp_q.size()), '0);
    end

    // Saturation: 39 credits with ready low leave 15 pending and 24 dropped.
    do_reset(2);
    set_in(2, 2'b01, 1'b0);
    for (int c = 0; c < 40; c++) step();
    check("sat_pending_any", CW'(pa[2]), CW'(1));
`ifdef PM_STATS_EN
    check("sat_drop_count0", CW'(drops[2][15:0]), CW'(24));
    check("sat_drop_count1", CW'(drops[2][31:16]), '0);
`endif
    push_n(15, 0, 1'b0);
    gap_exp = 1;
    set_in(2, 2'b00, 1'b1);
    for (int c = 0; c < 20; c++) step();
    check("sat_drain_count", CW'(wr_cnt), CW'(15));
    check("sat_drain_leftover", CW'(exp_q.size()), '0);
    check("sat_drained_pending_any", CW'(pa[2]), '0);

    // Credit and issue on the same edge keep pending at 1.
    do_reset(2);
    push_n(8, 0, 1'b0);
    gap_exp = 1;
    set_in(2, 2'b01, 1'b1);
    for (int c = 0; c < 10; c++) step();
    check("ci_write_count", CW'(wr_cnt), CW'(8));
    check("ci_pending_any", CW'(pa[2]), CW'(1));
    push_n(1, 0, 1'b0);
    set_in(2, 2'b00, 1'b1);
    for (int c = 0; c < 5; c++) step();
    check("ci_tail_count", CW'(wr_cnt), CW'(9));
    check("ci_leftover", CW'(exp_q.size()), '0);
    check("ci_final_pending_any", CW'(pa[2]), '0);

    // Reset mid-stream with five pending and writes in flight.
    do_reset(2);
    set_in(2, 2'b01, 1'b0);
    for (int c = 0; c < 6; c++) step();
    push_n(2, 0, 1'b0);
    set_in(2, 2'b01, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_we", CW'(we[2]), '0);
    check("rst_outputs", bundle[2], '0);
    check("rst_pending_any", CW'(pa[2]), '0);
    set_in(2, 2'b00, 1'b1);
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("rst_write_count", CW'(wr_cnt), CW'(2));
    check("rst_leftover", CW'(exp_q.size()), '0);

    // Disabling a flow with three pending still drains exactly three.
    do_reset(2);
    set_in(2, 2'b01, 1'b0);
    for (int c = 0; c < 4; c++) step();
    push_n(3, 0, 1'b0);
    gap_exp = 1;
    set_in(2, 2'b00, 1'b1);
    for (int c = 0; c < 12; c++) step();
    check("dis_write_count", CW'(wr_cnt), CW'(3));
    check("dis_leftover", CW'(exp_q.size()), '0);
    check("dis_pending_any", CW'(pa[2]), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
